// File: rtl/imem_loader.sv
// Boot loader: assembles a big-endian byte stream into 32-bit words and writes
// them to instruction memory. Define IMEM_LOADER_CHECKSUM_EN to add a trailing checksum word.
module imem_loader #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] END_MARK = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow,
  output logic              chk_err
);
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHK, DONE} state_t;

  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

  state_t              state, nxt;
  logic [1:0]          idx;
  logic [23:0]         part;
  logic [ADDR_W-1:0]   ptr;
  logic [31:0]         full;
  logic                take, last, restart;

  assign take    = byte_valid & byte_ready;
  assign last    = take && (idx == 2'd3);
  assign full    = {part, byte_data};
  assign restart = start && (state == IDLE || state == DONE);

  always_comb begin
    nxt        = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    cpu_hold   = 1'b1;
    case (state)
      IDLE: if (start) nxt = RECV;
      RECV: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (last) begin
          if (full == END_MARK)
`ifdef IMEM_LOADER_CHECKSUM_EN
            nxt = CHK;
`else
            nxt = DONE;
`endif
          else if (word_count == CAP) nxt = DONE;
          else                        nxt = WRITE;
        end
      end
      WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
        nxt    = RECV;
      end
      CHK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (last) nxt = DONE;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = overflow | chk_err;
        if (start) nxt = RECV;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= 2'd0;
      part       <= 24'd0;
      ptr        <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
    end else begin
      state <= nxt;
      if (restart) begin
        idx        <= 2'd0;
        ptr        <= '0;
        word_count <= '0;
        overflow   <= 1'b0;
      end
      if (take) begin
        idx  <= idx + 2'd1;
        part <= {part[15:0], byte_data};
      end
      // Capacity check happens before the write, so a wrapped pointer never overwrites word 0.
      if (state == RECV && last && full != END_MARK) begin
        if (word_count == CAP) overflow <= 1'b1;
        else begin
          mem_addr  <= ptr;
          mem_wdata <= full;
        end
      end
      if (state == WRITE) begin
        ptr        <= ptr + 1'b1;
        word_count <= word_count + 1'b1;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] csum;

  always_ff @(posedge clk) begin
    if (!reset) begin
      csum    <= 32'd0;
      chk_err <= 1'b0;
    end else begin
      if (restart) begin
        csum    <= 32'd0;
        chk_err <= 1'b0;
      end
      if (state == WRITE) csum <= csum + mem_wdata;
      if (state == CHK && last) chk_err <= (full != csum);
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule
